// File: rtl/stream_demux1t2_32_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer: default word width,
// per-channel buffer depth, channel indices and the buffer occupancy encoding.
package stream_demux1t2_32_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int CH0        = 0;
    localparam int CH1        = 1;

    // Occupancy of a 2-entry channel buffer
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'(FIFO_DEPTH)
    } occ_e;

endpackage

// File: rtl/stream_demux1t2_32_fifo2.sv
// Two-entry FIFO used as the per-channel output buffer. The head entry drives
// the output directly, so a pushed word is visible the cycle after the push.
// When the FIFO drains, the head keeps the last word that left it.
module stream_demux1t2_32_fifo2
    import stream_demux1t2_32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    occ_e             r_occ;
    logic             w_push;
    logic             w_pop;

    // Requests are only honoured when they make sense for the current fill level
    always_comb begin
        w_push  = i_push & (r_occ != OCC_FULL);
        w_pop   = i_pop & (r_occ != OCC_EMPTY);
        o_full  = (r_occ == OCC_FULL);
        o_empty = (r_occ == OCC_EMPTY);
        o_data  = r_head;
    end

    // Head/tail storage and occupancy; a push+pop at one entry replaces the head
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= OCC_EMPTY;
        end else begin
            case (r_occ)
                OCC_EMPTY: begin
                    if (w_push) begin
                        r_head <= i_data;
                        r_occ  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    case ({w_push, w_pop})
                        2'b10: begin
                            r_tail <= i_data;
                            r_occ  <= OCC_FULL;
                        end
                        2'b01: begin
                            r_occ <= OCC_EMPTY;
                        end
                        2'b11: begin
                            r_head <= i_data;
                        end
                        default: begin
                            r_occ <= OCC_ONE;
                        end
                    endcase
                end
                OCC_FULL: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        r_occ  <= OCC_ONE;
                    end
                end
                default: begin
                    r_occ <= OCC_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/stream_demux1t2_32.sv
// Registered 1-to-2 stream demultiplexer. Each accepted word is steered by its
// select bit into one of two independent 2-entry channel buffers, and a
// wrapping per-channel counter records how many words each channel received.
module stream_demux1t2_32
    import stream_demux1t2_32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] o0_data,
    output logic             o0_valid,
    input  logic             o0_ready,
    output logic [WIDTH-1:0] o1_data,
    output logic             o1_valid,
    input  logic             o1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic             w_full0;
    logic             w_full1;
    logic             w_empty0;
    logic             w_empty1;
    logic             w_toCh0;
    logic             w_push0;
    logic             w_push1;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Select decode and readiness; readiness looks only at the addressed buffer's fill
    always_comb begin
        w_toCh0  = (in_sel == 1'(CH0));
        in_ready = w_toCh0 ? ~w_full0 : ~w_full1;
        w_push0  = in_valid & in_ready & w_toCh0;
        w_push1  = in_valid & in_ready & ~w_toCh0;
        o0_valid = ~w_empty0;
        o1_valid = ~w_empty1;
        cnt0     = r_cnt0;
        cnt1     = r_cnt1;
    end

    // Routed-word counters advance on the same edge as the push they count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_push0) begin
                r_cnt0 <= r_cnt0 + 1'b1;
            end
            if (w_push1) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end
        end
    end

    stream_demux1t2_32_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push0),
        .i_pop   (o0_ready),
        .i_data  (in_data),
        .o_full  (w_full0),
        .o_empty (w_empty0),
        .o_data  (o0_data)
    );

    stream_demux1t2_32_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push1),
        .i_pop   (o1_ready),
        .i_data  (in_data),
        .o_full  (w_full1),
        .o_empty (w_empty1),
        .o_data  (o1_data)
    );

endmodule

// File: tb/tb_stream_demux1t2_32.sv
// Bench for the 1-to-2 stream demultiplexer: directed steps with a queue
// scoreboard per channel, plus a long run that wraps the channel 0 counter.
module tb_stream_demux1t2_32;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] o0_data;
    logic        o0_valid;
    logic        o0_ready;
    logic [31:0] o1_data;
    logic        o1_valid;
    logic        o1_ready;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    int          checks;
    int          failures;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] last0;
    logic [31:0] last1;
    logic [15:0] mCnt0;
    logic [15:0] mCnt1;

    stream_demux1t2_32 dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .o0_data  (o0_data),
        .o0_valid (o0_valid),
        .o0_ready (o0_ready),
        .o1_data  (o1_data),
        .o1_valid (o1_valid),
        .o1_ready (o1_ready),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and counts and reports it when it does not hold
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs with the model, update the model, advance
    task automatic applyStimulus(input bit doCheck);
        logic [31:0] expHead0;
        logic [31:0] expHead1;
        bit          expReady;
        bit          pop0;
        bit          pop1;
        #3;
        expHead0 = (q0.size() != 0) ? q0[0] : last0;
        expHead1 = (q1.size() != 0) ? q1[0] : last1;
        expReady = in_sel ? (q1.size() != 2) : (q0.size() != 2);
        if (doCheck) begin
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expReady});
            checkOutput("o0_valid", {31'd0, o0_valid}, {31'd0, q0.size() != 0});
            checkOutput("o1_valid", {31'd0, o1_valid}, {31'd0, q1.size() != 0});
            checkOutput("o0_data", o0_data, expHead0);
            checkOutput("o1_data", o1_data, expHead1);
            checkOutput("cnt0", {16'd0, cnt0}, {16'd0, mCnt0});
            checkOutput("cnt1", {16'd0, cnt1}, {16'd0, mCnt1});
        end
        if (rst) begin
            q0.delete();
            q1.delete();
            last0 = '0;
            last1 = '0;
            mCnt0 = '0;
            mCnt1 = '0;
        end else begin
            pop0 = (q0.size() != 0) && o0_ready;
            pop1 = (q1.size() != 0) && o1_ready;
            if (pop0) last0 = q0.pop_front();
            if (pop1) last1 = q1.pop_front();
            if (in_valid && expReady) begin
                if (in_sel) begin
                    q1.push_back(in_data);
                    mCnt1 = mCnt1 + 16'd1;
                end else begin
                    q0.push_back(in_data);
                    mCnt0 = mCnt0 + 16'd1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Directed sequence
    initial begin
        checks   = 0;
        failures = 0;
        last0    = '0;
        last1    = '0;
        mCnt0    = '0;
        mCnt1    = '0;
        rst      = 1'b1;
        in_data  = '0;
        in_sel   = 1'b0;
        in_valid = 1'b0;
        o0_ready = 1'b0;
        o1_ready = 1'b0;

        // Reset, then idle
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        rst = 1'b0;
        applyStimulus(1'b1);
        checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("idle_o0_data", o0_data, 32'd0);

        // One word to each channel with consumers ready
        o0_ready = 1'b1;
        o1_ready = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'hA5A5_0001;
        applyStimulus(1'b1);
        #1;
        checkOutput("first_o0_data", o0_data, 32'hA5A5_0001);
        in_sel  = 1'b1;
        in_data = 32'h5A5A_0002;
        applyStimulus(1'b1);
        #1;
        checkOutput("first_o1_data", o1_data, 32'h5A5A_0002);
        in_valid = 1'b0;
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("first_cnt1", {16'd0, cnt1}, 32'd1);

        // Fill channel 0 while its consumer stalls
        o0_ready = 1'b0;
        o1_ready = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'h10;
        applyStimulus(1'b1);
        in_data = 32'h11;
        applyStimulus(1'b1);
        in_data = 32'h12;
        #1;
        checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
        applyStimulus(1'b1);

        // Channel 1 keeps flowing while channel 0 is full
        in_sel  = 1'b1;
        in_data = 32'h20;
        #1;
        checkOutput("ch1_ready_while_ch0_full", {31'd0, in_ready}, 32'd1);
        applyStimulus(1'b1);
        #1;
        checkOutput("ch1_word_seen", o1_data, 32'h20);
        checkOutput("ch0_head_kept", o0_data, 32'h10);

        // Push and pop together on channel 1 at one entry
        o1_ready = 1'b1;
        in_data  = 32'h31;
        applyStimulus(1'b1);
        #1;
        checkOutput("pushpop_head", o1_data, 32'h31);
        checkOutput("pushpop_valid", {31'd0, o1_valid}, 32'd1);
        o1_ready = 1'b0;

        // Release channel 0 and deliver the stalled third word
        in_sel   = 1'b0;
        in_data  = 32'h12;
        o0_ready = 1'b1;
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1);
        checkOutput("cnt0_after_fill", {16'd0, cnt0}, 32'd4);
        checkOutput("o0_drained_last", o0_data, 32'h12);

        // Stream into channel 0 until its counter reaches its top value
        o0_ready = 1'b1;
        o1_ready = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        for (int i = 0; i < 70000 && mCnt0 != 16'hFFFF; i++) begin
            in_data = $urandom;
            applyStimulus(1'b0);
        end
        checkOutput("cnt0_top", {16'd0, cnt0}, 32'h0000_FFFF);
        in_data = 32'hCAFE_0000;
        applyStimulus(1'b1);
        checkOutput("cnt0_wrap", {16'd0, cnt0}, 32'd0);

        // Load both buffers, then reset while a word is still being offered
        o0_ready = 1'b0;
        o1_ready = 1'b0;
        in_data  = 32'hBEEF_0001;
        applyStimulus(1'b1);
        in_data = 32'hBEEF_0002;
        applyStimulus(1'b1);
        in_sel  = 1'b1;
        in_data = 32'hBEEF_0003;
        applyStimulus(1'b1);
        rst = 1'b1;
        applyStimulus(1'b1);
        checkOutput("rst_o0_valid", {31'd0, o0_valid}, 32'd0);
        checkOutput("rst_o1_valid", {31'd0, o1_valid}, 32'd0);
        checkOutput("rst_o0_data", o0_data, 32'd0);
        checkOutput("rst_o1_data", o1_data, 32'd0);
        checkOutput("rst_cnt0", {16'd0, cnt0}, 32'd0);
        checkOutput("rst_cnt1", {16'd0, cnt1}, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        applyStimulus(1'b1);
        applyStimulus(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
